// File: rtl/irq_requester_if.sv
// Event/acknowledge bundle between peripheral event lines, the core's IRQ unit and irq_requester.
interface irq_requester_if #(
    parameter int unsigned NLINES = 30
);
    logic [NLINES-1:0] evt_i;
    logic [NLINES-1:0] mask_i;
    logic [31:0]       ack_i;
    logic              lost_clr_i;
    logic [31:0]       irq_o;
    logic [NLINES-1:0] pend_o;
    logic [NLINES-1:0] lost_o;

    // master: the requester itself; slave: the environment (peripherals + core IRQ unit)
    modport master (
        input  evt_i, mask_i, ack_i, lost_clr_i,
        output irq_o, pend_o, lost_o
    );

    modport slave (
        output evt_i, mask_i, ack_i, lost_clr_i,
        input  irq_o, pend_o, lost_o
    );
endinterface

// File: rtl/irq_requester.sv
// Converts rising edges on peripheral event lines into level interrupt requests held until acked.
// Optional macro IRQ_REQ_COALESCE_EN: queue up to 2^CNT_W-1 extra events per line instead of dropping them.
module irq_requester #(
    parameter int unsigned BASE   = 2,
    parameter int unsigned NLINES = 30,
    parameter int unsigned CNT_W  = 4
) (
    input  logic           clk,
    input  logic           rst,
    irq_requester_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    if (BASE + NLINES > 32 || NLINES == 0 || CNT_W == 0) begin : g_bad_params
        $error("irq_requester: parameters out of range");
    end

    logic [NLINES-1:0] evt_q;
    logic [NLINES-1:0] req;
    logic [NLINES-1:0] pend;
    logic [NLINES-1:0] lost;
    logic [31:0]       irq;
    logic              unused_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q <= '0;
        end else begin
            evt_q <= bus.evt_i;
        end
    end

    for (genvar k = 0; k < NLINES; k++) begin : g_line
        logic [1:0] state;
        logic [1:0] state_nxt;
        logic       rise;
        logic       ack;
        logic       drop;
        logic       lost_q;
`ifdef IRQ_REQ_COALESCE_EN
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
`endif

        assign rise = bus.evt_i[k] & ~evt_q[k] & ~bus.mask_i[k];
        assign ack  = bus.ack_i[BASE+k];

        always_comb begin
            state_nxt = state;
            drop      = 1'b0;
`ifdef IRQ_REQ_COALESCE_EN
            cnt_nxt   = cnt;
`endif
            case (state)
                S_IDLE: begin
                    if (rise) begin
                        state_nxt = S_REQ;
                    end
                end
                S_REQ: begin
                    if (ack) begin
                        // a rise arriving with the ack reuses the GAP slot, so it never needs the counter
                        if (rise) begin
                            state_nxt = S_GAP;
`ifdef IRQ_REQ_COALESCE_EN
                        end else if (cnt != '0) begin
                            cnt_nxt   = cnt - 1'b1;
                            state_nxt = S_GAP;
`endif
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else if (rise) begin
`ifdef IRQ_REQ_COALESCE_EN
                        if (cnt == '1) begin
                            drop = 1'b1;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
`else
                        drop = 1'b1;
`endif
                    end
                end
                S_GAP: begin
                    state_nxt = S_REQ;
                    if (rise) begin
`ifdef IRQ_REQ_COALESCE_EN
                        if (cnt == '1) begin
                            drop = 1'b1;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
`else
                        drop = 1'b1;
`endif
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state  <= S_IDLE;
                lost_q <= 1'b0;
`ifdef IRQ_REQ_COALESCE_EN
                cnt    <= '0;
`endif
            end else begin
                state  <= state_nxt;
                lost_q <= drop | (lost_q & ~bus.lost_clr_i);
`ifdef IRQ_REQ_COALESCE_EN
                cnt    <= cnt_nxt;
`endif
            end
        end

        assign req[k]  = (state == S_REQ);
        assign pend[k] = (state != S_IDLE);
        assign lost[k] = lost_q;
    end

    always_comb begin
        irq                 = '0;
        irq[BASE +: NLINES] = req;
    end

    assign bus.irq_o  = irq;
    assign bus.pend_o = pend;
    assign bus.lost_o = lost;

    // ack bits outside the line range have no function
    assign unused_ok = &{1'b0, bus.ack_i};
endmodule

// File: tb/tb_irq_requester.sv
// Directed self-checking bench for irq_requester; covers both the default and IRQ_REQ_COALESCE_EN builds.
`timescale 1ns/1ps
module tb_irq_requester;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    irq_requester_if #(.NLINES(30)) bus ();

    irq_requester #(
        .BASE   (2),
        .NLINES (30),
        .CNT_W  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // inputs change and outputs are sampled at the falling edge
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_evt(input int k);
        bus.evt_i[k] = 1'b1;
        step(1);
        bus.evt_i[k] = 1'b0;
        step(1);
    endtask

    task automatic pulse_ack(input int b);
        bus.ack_i[b] = 1'b1;
        step(1);
        bus.ack_i[b] = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.lost_clr_i = 1'b1;
        step(1);
        bus.lost_clr_i = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        bus.evt_i      = '0;
        bus.mask_i     = '0;
        bus.ack_i      = '0;
        bus.lost_clr_i = 1'b0;
        step(3);
        rst = 1'b0;
        check("reset_irq", bus.irq_o, 32'h0);
        check("reset_pend", 32'(bus.pend_o), 32'h0);
        check("reset_lost", 32'(bus.lost_o), 32'h0);

        // basic request on line 0 (irq bit 2), event level held high
        bus.evt_i[0] = 1'b1;
        step(1);
        check("basic_irq", bus.irq_o, 32'h4);
        check("basic_pend", 32'(bus.pend_o), 32'h1);
        step(5);
        check("basic_hold", bus.irq_o, 32'h4);
        pulse_ack(2);
        check("basic_ack_irq", bus.irq_o, 32'h0);
        check("basic_ack_pend", 32'(bus.pend_o), 32'h0);
        check("basic_lost", 32'(bus.lost_o), 32'h0);
        bus.evt_i[0] = 1'b0;
        step(1);

        // extra rises on line 1 (irq bit 3) while requesting
        pulse_evt(1);
        check("sat_req", bus.irq_o, 32'h8);
`ifdef IRQ_REQ_COALESCE_EN
        repeat (5) pulse_evt(1);
`else
        pulse_evt(1);
`endif
        check("sat_lost", 32'(bus.lost_o), 32'h2);
        check("sat_irq", bus.irq_o, 32'h8);
        pulse_clr();
        check("lost_clr", 32'(bus.lost_o), 32'h0);
        // dropped rise coincident with a clear keeps the lost bit
        bus.evt_i[1]   = 1'b1;
        bus.lost_clr_i = 1'b1;
        step(1);
        bus.evt_i[1]   = 1'b0;
        bus.lost_clr_i = 1'b0;
        check("set_wins", 32'(bus.lost_o), 32'h2);
        step(1);
        pulse_clr();
        check("lost_clr2", 32'(bus.lost_o), 32'h0);
`ifdef IRQ_REQ_COALESCE_EN
        for (int i = 0; i < 3; i++) begin
            pulse_ack(3);
            check("sat_gap", bus.irq_o, 32'h0);
            check("sat_gap_pend", 32'(bus.pend_o), 32'h2);
            step(1);
            check("sat_rereq", bus.irq_o, 32'h8);
        end
`endif
        pulse_ack(3);
        check("sat_idle_irq", bus.irq_o, 32'h0);
        check("sat_idle_pend", 32'(bus.pend_o), 32'h0);
        step(1);

`ifdef IRQ_REQ_COALESCE_EN
        // coalesce on line 3 (irq bit 5), acks 5 cycles apart
        pulse_evt(3);
        repeat (3) pulse_evt(3);
        check("coal_lost", 32'(bus.lost_o), 32'h0);
        for (int i = 0; i < 4; i++) begin
            pulse_ack(5);
            check("coal_after_ack", bus.irq_o, 32'h0);
            check("coal_pend", 32'(bus.pend_o), (i < 3) ? 32'h8 : 32'h0);
            step(1);
            check("coal_next", bus.irq_o, (i < 3) ? 32'h20 : 32'h0);
            step(3);
        end
`endif

        // masked rise on line 4 (irq bit 6) is ignored
        bus.mask_i[4] = 1'b1;
        pulse_evt(4);
        check("mask_irq", bus.irq_o, 32'h0);
        check("mask_pend", 32'(bus.pend_o), 32'h0);
        bus.mask_i[4] = 1'b0;
        pulse_evt(4);
        check("unmask_irq", bus.irq_o, 32'h40);
        bus.mask_i[4] = 1'b1;
        step(3);
        check("mask_hold", bus.irq_o, 32'h40);
        pulse_ack(6);
        check("mask_ack", bus.irq_o, 32'h0);
        bus.mask_i[4] = 1'b0;
        step(1);

        // rise and ack together on line 7 (irq bit 9)
        pulse_evt(7);
        check("ra_req", bus.irq_o, 32'h200);
        bus.evt_i[7] = 1'b1;
        bus.ack_i[9] = 1'b1;
        step(1);
        bus.evt_i[7] = 1'b0;
        bus.ack_i[9] = 1'b0;
        check("ra_gap", bus.irq_o, 32'h0);
        check("ra_gap_pend", 32'(bus.pend_o), 32'h80);
        step(1);
        check("ra_rereq", bus.irq_o, 32'h200);
        check("ra_lost", 32'(bus.lost_o), 32'h0);
        pulse_ack(9);
        check("ra_idle", 32'(bus.pend_o), 32'h0);
        step(1);

        // stray acks with every line idle
        bus.ack_i = 32'hFFFF_FFFF;
        step(1);
        bus.ack_i = '0;
        check("stray_irq", bus.irq_o, 32'h0);
        check("stray_pend", 32'(bus.pend_o), 32'h0);
        check("stray_lost", 32'(bus.lost_o), 32'h0);
        step(1);

        // acks on core-internal bits leave line 0 requesting
        pulse_evt(0);
        bus.ack_i = 32'h3;
        step(1);
        bus.ack_i = '0;
        check("low_ack", bus.irq_o, 32'h4);

        // reset mid-operation with lines 0 and 2 requesting
        pulse_evt(2);
`ifdef IRQ_REQ_COALESCE_EN
        repeat (2) pulse_evt(2);
        repeat (4) pulse_evt(0);
        check("pre_rst_lost", 32'(bus.lost_o), 32'h1);
`else
        pulse_evt(2);
        check("pre_rst_lost", 32'(bus.lost_o), 32'h4);
`endif
        check("pre_rst_irq", bus.irq_o, 32'h14);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst_irq", bus.irq_o, 32'h0);
        check("rst_pend", 32'(bus.pend_o), 32'h0);
        check("rst_lost", 32'(bus.lost_o), 32'h0);
        step(5);
        check("rst_quiet_irq", bus.irq_o, 32'h0);
        check("rst_quiet_pend", 32'(bus.pend_o), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
